// File: rtl/game_timer_pkg.sv
// Shared definitions for the round timer: state encodings, BCD digit constants
// and the elaboration-time decimal-to-BCD helper.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Two-digit packed BCD {tens, ones}; callers keep value within 0..99.
  function automatic logic [7:0] to_bcd(input int unsigned value);
    return {4'((value / 10) % 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/game_timer_ctrl_if.sv
// Command/status bundle between the game FSM (master) and the round timer (slave).
// Commands are single-cycle pulses; status outputs are registered by the timer.
interface game_timer_ctrl_if;

  logic       Start;
  logic       PauseToggle;
  logic       Abort;
  logic [3:0] OnesValue;
  logic [3:0] TensValue;
  logic       Running;
  logic       Paused;
  logic       Expired;
  logic       TimeUp;
  logic       Warning;

  modport master (
    output Start, PauseToggle, Abort,
    input  OnesValue, TensValue, Running, Paused, Expired, TimeUp, Warning
  );

  modport slave (
    input  Start, PauseToggle, Abort,
    output OnesValue, TensValue, Running, Paused, Expired, TimeUp, Warning
  );

endinterface

// File: rtl/game_timer_ctrl_tick_prescaler.sv
// 1 Hz prescaler: down-counter emitting a one-cycle Tick at count 0, then reloading.
// Load restarts the count; Hold freezes it (a held count of 0 ticks once released).
module tick_prescaler #(
  parameter int CLOCK_FREQUENCY = 50000000
) (
  input  logic ClockIn,
  input  logic Reset,
  input  logic Load,
  input  logic Hold,
  output logic Tick
);

  localparam int            CW     = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLOCK_FREQUENCY - 1);

  logic [CW-1:0] count;

  assign Tick = !Hold && !Load && (count == '0);

  always_ff @(posedge ClockIn) begin
    if (Reset || Load) begin
      count <= RELOAD;
    end else if (!Hold) begin
      count <= (count == '0) ? RELOAD : count - CW'(1);
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round timer: IDLE/RUN/PAUSE/EXPIRED FSM driving a two-digit BCD countdown; commands act one edge later.
// Optional low-time Warning output built only when TIMER_WARN_EN is defined (tied to 0 otherwise).
module game_timer_ctrl
  import game_timer_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int ROUND_SECONDS   = 60,
  parameter int WARN_SECONDS    = 10
) (
  input  logic             ClockIn,
  input  logic             Reset,
  game_timer_ctrl_if.slave timer_bus
);

  localparam logic [7:0] ROUND_BCD  = to_bcd(ROUND_SECONDS);
  localparam logic [3:0] ROUND_TENS = ROUND_BCD[7:4];
  localparam logic [3:0] ROUND_ONES = ROUND_BCD[3:0];

  timer_state_t state, state_nxt;
  logic [3:0]   ones, tens, ones_nxt, tens_nxt;
  logic         timeup_nxt, warn_nxt;
  logic         pre_load, pre_hold, tick;

  tick_prescaler #(.CLOCK_FREQUENCY(CLOCK_FREQUENCY)) u_prescaler (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .Load    (pre_load),
    .Hold    (pre_hold),
    .Tick    (tick)
  );

  always_comb begin
    state_nxt  = state;
    ones_nxt   = ones;
    tens_nxt   = tens;
    timeup_nxt = 1'b0;
    pre_load   = 1'b0;
    pre_hold   = 1'b1;
    if (timer_bus.Abort) begin
      state_nxt = IDLE;
      ones_nxt  = ROUND_ONES;
      tens_nxt  = ROUND_TENS;
    end else begin
      case (state)
        IDLE, EXPIRED: begin
          if (timer_bus.Start) begin
            pre_load = 1'b1;
            ones_nxt = ROUND_ONES;
            tens_nxt = ROUND_TENS;
            if (ROUND_SECONDS == 0) begin
              state_nxt  = EXPIRED;
              timeup_nxt = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          // A pause landing on a tick keeps the prescaler at 0, so the tick replays on resume.
          if (timer_bus.PauseToggle) begin
            state_nxt = PAUSE;
          end else begin
            pre_hold = 1'b0;
            if (tick) begin
              if (ones == BCD_ZERO) begin
                ones_nxt = BCD_NINE;
                tens_nxt = tens - 4'd1;
              end else begin
                ones_nxt = ones - 4'd1;
              end
              if (tens == BCD_ZERO && ones == 4'd1) begin
                state_nxt  = EXPIRED;
                timeup_nxt = 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (timer_bus.PauseToggle) state_nxt = RUN;
        end
      endcase
    end
  end

`ifdef TIMER_WARN_EN
  localparam logic [6:0] WARN_LIMIT = 7'(WARN_SECONDS);
  logic [6:0] remaining_nxt;

  always_comb begin
    remaining_nxt = 7'(tens_nxt) * 7'd10 + 7'(ones_nxt);
    warn_nxt = (state_nxt == RUN || state_nxt == PAUSE) &&
               (remaining_nxt != 7'd0) && (remaining_nxt <= WARN_LIMIT);
  end
`else
  assign warn_nxt = 1'b0;
`endif

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state             <= IDLE;
      ones              <= ROUND_ONES;
      tens              <= ROUND_TENS;
      timer_bus.Running <= 1'b0;
      timer_bus.Paused  <= 1'b0;
      timer_bus.Expired <= 1'b0;
      timer_bus.TimeUp  <= 1'b0;
      timer_bus.Warning <= 1'b0;
    end else begin
      state             <= state_nxt;
      ones              <= ones_nxt;
      tens              <= tens_nxt;
      timer_bus.Running <= (state_nxt == RUN);
      timer_bus.Paused  <= (state_nxt == PAUSE);
      timer_bus.Expired <= (state_nxt == EXPIRED);
      timer_bus.TimeUp  <= timeup_nxt;
      timer_bus.Warning <= warn_nxt;
    end
  end

  assign timer_bus.OnesValue = ones;
  assign timer_bus.TensValue = tens;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl: seconds-and-cycles reference model checked every cycle,
// directed round scenarios with literal expectations, then randomized command traffic.
module tb_game_timer_ctrl;

  localparam int CF = 4;
  localparam int RS = 12;
  localparam int WS = 10;
`ifdef TIMER_WARN_EN
  localparam int WARN_ON = 1;
`else
  localparam int WARN_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst0 = 1'b0;
  always #5 clk = ~clk;

  game_timer_ctrl_if bus ();
  game_timer_ctrl_if bus0 ();

  game_timer_ctrl #(.CLOCK_FREQUENCY(CF), .ROUND_SECONDS(RS), .WARN_SECONDS(WS)) dut (
    .ClockIn   (clk),
    .Reset     (rst),
    .timer_bus (bus)
  );

  game_timer_ctrl #(.CLOCK_FREQUENCY(CF), .ROUND_SECONDS(0), .WARN_SECONDS(WS)) dut0 (
    .ClockIn   (clk),
    .Reset     (rst0),
    .timer_bus (bus0)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: mode 0 idle, 1 run, 2 pause, 3 expired; seconds left; RUN cycles into current second.
  int m_st  = 0;
  int m_rem = RS;
  int m_el  = 0;
  bit m_tu  = 1'b0;

  always @(posedge clk) begin : model
    int s, r, e;
    bit tu;
    s = m_st; r = m_rem; e = m_el; tu = 1'b0;
    if (rst) begin
      s = 0; r = RS; e = 0;
    end else if (bus.Abort) begin
      s = 0; r = RS;
    end else if (bus.Start && (s == 0 || s == 3)) begin
      r = RS; e = 0; s = 1;
    end else if (bus.PauseToggle && s == 1) begin
      s = 2;
    end else if (bus.PauseToggle && s == 2) begin
      s = 1;
    end else if (s == 1) begin
      e = e + 1;
      if (e == CF) begin
        e = 0;
        r = r - 1;
        if (r == 0) begin
          s = 3; tu = 1'b1;
        end
      end
    end
    m_st <= s; m_rem <= r; m_el <= e; m_tu <= tu;
  end

  always @(negedge clk) begin : compare
    logic [12:0] act, exp;
    bit w;
    if (chk_en) begin
      w = (WARN_ON != 0) && (m_st == 1 || m_st == 2) && (m_rem > 0) && (m_rem <= WS);
      act = {bus.TensValue, bus.OnesValue, bus.Running, bus.Paused, bus.Expired, bus.TimeUp, bus.Warning};
      exp = {4'(m_rem / 10), 4'(m_rem % 10), m_st == 1, m_st == 2, m_st == 3, m_tu, w};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_compare t=%0t dut={T,O,run,pau,exp,tu,warn}=%h model=%h", $time, act, exp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic digits(input string nm, input int t, input int o);
    pin({nm, " tens"}, int'(bus.TensValue), t);
    pin({nm, " ones"}, int'(bus.OnesValue), o);
    pin({nm, " model secs"}, m_rem, t * 10 + o);
  endtask

  function automatic int status();
    return int'({bus.Running, bus.Paused, bus.Expired, bus.TimeUp, bus.Warning});
  endfunction

  task automatic pulse_start();
    bus.Start = 1'b1; cyc(1); bus.Start = 1'b0;
  endtask

  task automatic pulse_pause();
    bus.PauseToggle = 1'b1; cyc(1); bus.PauseToggle = 1'b0;
  endtask

  initial begin
    bus.Start = 1'b0; bus.PauseToggle = 1'b0; bus.Abort = 1'b0;
    bus0.Start = 1'b0; bus0.PauseToggle = 1'b0; bus0.Abort = 1'b0;
    rst = 1'b1; rst0 = 1'b1;
    cyc(2);
    rst = 1'b0; rst0 = 1'b0;
    chk_en = 1'b1;

    digits("reset", 1, 2);
    pin("reset status", status(), 0);
    pin("r0 reset digits", int'({bus0.TensValue, bus0.OnesValue}), 0);

    // Full round: one decrement every CF cycles, expiry 48 cycles after Running rises.
    pulse_start();
    pin("start running", int'(bus.Running), 1);
    digits("start", 1, 2);
    cyc(4);  digits("sec1", 1, 1);
    cyc(4);  digits("sec2", 1, 0);
    pin("warning at 10", int'(bus.Warning), WARN_ON);
    cyc(4);  digits("sec3 wrap", 0, 9);
    cyc(35); digits("last second", 0, 1);
    pin("not yet expired", int'(bus.Expired), 0);
    cyc(1);  digits("expiry", 0, 0);
    pin("expiry timeup", int'(bus.TimeUp), 1);
    pin("expiry expired", int'(bus.Expired), 1);
    pin("expiry running", int'(bus.Running), 0);
    pin("model timeup", int'(m_tu), 1);
    cyc(1);
    pin("timeup one cycle", int'(bus.TimeUp), 0);
    pin("expired holds", int'(bus.Expired), 1);

    // Restart, then pause mid-second.
    pulse_start();
    digits("restart", 1, 2);
    pin("restart running", int'(bus.Running), 1);
    cyc(2);
    pulse_pause();
    pin("paused", int'(bus.Paused), 1);
    cyc(20);
    digits("frozen", 1, 2);
    pin("still paused", int'(bus.Paused), 1);
    pulse_pause();
    pin("resumed", int'(bus.Running), 1);
    cyc(1);  digits("resume+1", 1, 2);
    cyc(1);  digits("resume+2", 1, 1);

    // Pause on the exact tick cycle: the decrement lands right after resume.
    cyc(3);
    pulse_pause();
    digits("pause on tick", 1, 1);
    pin("pause on tick paused", int'(bus.Paused), 1);
    cyc(5);  digits("tick held", 1, 1);
    pulse_pause();
    digits("resume tick pending", 1, 1);
    cyc(1);  digits("replayed tick", 1, 0);

    // Abort from PAUSE.
    pulse_pause();
    bus.Abort = 1'b1; cyc(1); bus.Abort = 1'b0;
    digits("abort pause", 1, 2);
    pin("abort pause status", status(), 0);

    // Start+Abort together from EXPIRED.
    pulse_start();
    cyc(48);
    pin("expired again", int'(bus.Expired), 1);
    bus.Start = 1'b1; bus.Abort = 1'b1; cyc(1); bus.Start = 1'b0; bus.Abort = 1'b0;
    digits("start+abort", 1, 2);
    pin("start+abort status", status(), 0);

    // Reset mid-round at 05.
    pulse_start();
    cyc(28);
    digits("before reset", 0, 5);
    rst = 1'b1; cyc(1); rst = 1'b0;
    digits("mid reset", 1, 2);
    pin("mid reset status", status(), 0);

    // Zero-length round.
    bus0.Start = 1'b1; cyc(1); bus0.Start = 1'b0;
    pin("r0 expired", int'(bus0.Expired), 1);
    pin("r0 timeup", int'(bus0.TimeUp), 1);
    pin("r0 running", int'(bus0.Running), 0);
    pin("r0 digits", int'({bus0.TensValue, bus0.OnesValue}), 0);
    cyc(1);
    pin("r0 timeup one cycle", int'(bus0.TimeUp), 0);

    // Random command traffic against the model.
    repeat (3000) begin
      bus.Start       = ($urandom_range(0, 999) < 50);
      bus.PauseToggle = ($urandom_range(0, 999) < 30);
      bus.Abort       = ($urandom_range(0, 999) < 8);
      rst             = ($urandom_range(0, 999) < 3);
      cyc(1);
    end
    bus.Start = 1'b0; bus.PauseToggle = 1'b0; bus.Abort = 1'b0; rst = 1'b0;
    cyc(2);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Round-timer controller for the ByteBasher game: sequences a two-digit BCD countdown of the seconds left in a round. It owns the 1 Hz prescaler and the digit registers, accepts start/pause/abort commands from the game FSM, and signals round expiry. Its digit outputs drive the HEX0/HEX1 hex decoders directly.

## Interface
- CLOCK_FREQUENCY, 50000000: clock cycles per countdown second.
- ROUND_SECONDS, 60: round length in seconds, decimal 0..99, converted to BCD at elaboration.
- WARN_SECONDS, 10: remaining-time threshold for Warning, decimal 0..99.
- ClockIn  in  1  system clock; the block's only clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  single-cycle pulse; begins a round from IDLE or EXPIRED.
- PauseToggle  in  1  single-cycle pulse; RUN→PAUSE or PAUSE→RUN.
- Abort  in  1  single-cycle pulse; returns to IDLE from any state.
- OnesValue  out  4  BCD ones digit of the remaining seconds.
- TensValue  out  4  BCD tens digit of the remaining seconds.
- Running  out  1  high in RUN.
- Paused  out  1  high in PAUSE.
- Expired  out  1  high in EXPIRED.
- TimeUp  out  1  one-cycle pulse on entry to EXPIRED.
- Warning  out  1  low-time indicator; see Configuration.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. All outputs are registered.
- Reset: state goes to IDLE, digits load BCD(ROUND_SECONDS), and the prescaler loads CLOCK_FREQUENCY-1. Running, Paused, Expired, TimeUp and Warning are all 0.
- Command priority within one cycle: Reset > Abort > Start > PauseToggle > tick.
- IDLE: digits hold the loaded value. Start → RUN, with the prescaler reloaded to CLOCK_FREQUENCY-1.
- RUN: the prescaler decrements every cycle. At 0 it generates a tick and reloads to CLOCK_FREQUENCY-1.
- On a tick, the BCD count decrements:
  - If ones = 0, ones becomes 9 and tens decrements.
  - Otherwise, ones decrements.
  - A tick at 01 gives 00 and enters EXPIRED.
- PauseToggle in RUN → PAUSE. The prescaler and digits freeze at their current values.
  - If PauseToggle coincides with a tick, the pause wins and the tick is dropped. The prescaler holds at 0, so the tick fires on the first RUN cycle after resume.
- PAUSE: PauseToggle → RUN, resuming from the frozen prescaler value. Start is ignored.
- EXPIRED: digits hold 00. Start → RUN with reloaded digits and prescaler. PauseToggle is ignored.
- Start while in RUN or PAUSE is ignored.
- Abort in RUN, PAUSE or EXPIRED → IDLE with reloaded digits. Abort in IDLE has no effect.
- ROUND_SECONDS = 0: Start goes directly to EXPIRED with a TimeUp pulse. The digits read 00.
- Width rules:
  - The prescaler is $clog2(CLOCK_FREQUENCY) bits wide, with a minimum of 1 bit.
  - The digits never hold values above 9.
  - Warning compares the decimal value tens*10+ones, computed at 7 bits.

## Timing
- A command sampled at edge N is reflected in state and outputs after edge N, i.e. from cycle N+1.
- The first digit decrement becomes visible exactly CLOCK_FREQUENCY cycles after Running rises. Later decrements follow every CLOCK_FREQUENCY RUN cycles; cycles spent in PAUSE do not count.
- TimeUp is high for exactly one cycle: the first cycle of EXPIRED, coincident with Expired rising and the digits reading 00. Running falls in the same cycle.
- Reset mid-round takes effect at the next edge with no residual TimeUp.

## Configuration
- TIMER_WARN_EN defined:
  - Warning = 1 while in RUN or PAUSE with 0 < remaining ≤ WARN_SECONDS.
  - Warning = 0 in IDLE and EXPIRED.
  - Warning updates in the same cycle as the digits.
- TIMER_WARN_EN undefined: Warning is tied to 0 and the comparator logic is not built.

## Structure
- Shared package/include game_timer_pkg holds:
  - the state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3);
  - the BCD constants (BCD_NINE=4'd9, BCD_ZERO=4'd0);
  - the decimal-to-BCD conversion function used for ROUND_SECONDS.
- Sub-module tick_prescaler, parameterised by CLOCK_FREQUENCY:
  - inputs: ClockIn, Reset, Load, Hold;
  - output: a one-cycle Tick at count 0.
- The FSM and the BCD down-counter stay in game_timer_ctrl.

## Test plan
Bench parameters: CLOCK_FREQUENCY=4, ROUND_SECONDS=12, WARN_SECONDS=10.
- Reset, then Start → Running=1 next cycle; digits read 1,2 → 1,1 after 4 cycles → 1,0 after 8 cycles → 0,9 after 12 cycles (ones wraps, tens decrements); Warning=1 from 1,0 onward with TIMER_WARN_EN.
- Run to the end → digits 0,0, Expired=1, TimeUp high for exactly 1 cycle, 48 cycles after Running rose; a further Start reloads 1,2 and runs.
- Start, wait 2 cycles, PauseToggle, hold 20 cycles, PauseToggle → digits frozen at 1,2 during the pause; 1,1 appears 2 RUN cycles after resume.
- PauseToggle on the same cycle as a tick → PAUSE with the digits not decremented; the decrement lands on the first cycle after resume.
- Abort during PAUSE, and separately Start+Abort on the same cycle from EXPIRED → IDLE, digits 1,2, all status outputs 0.
- Reset asserted mid-RUN at 0,5 → next cycle IDLE, digits 1,2, TimeUp never pulses; with ROUND_SECONDS=0, Start → Expired=1 and TimeUp pulse next cycle.
